// File: rtl/std_fp_div_seq_if.sv
// Go/done handshake and result bus of the sequential fixed-point divider.
// The requester drives go and the operands; the divider drives results and status.
interface std_fp_div_seq_if #(
  parameter int WIDTH = 32
);
  logic             go;
  logic [WIDTH-1:0] left;
  logic [WIDTH-1:0] right;
  logic [WIDTH-1:0] out_quotient;
  logic [WIDTH-1:0] out_remainder;
  logic             done;
  logic             busy;
  logic             div_by_zero;
  logic             overflow;

  modport master (
    output go, left, right,
    input  out_quotient, out_remainder, done, busy, div_by_zero, overflow
  );

  modport slave (
    input  go, left, right,
    output out_quotient, out_remainder, done, busy, div_by_zero, overflow
  );
endinterface

// File: rtl/std_fp_div_seq.sv
// Restoring shift-subtract divider computing (left << FRAC_WIDTH) / right, one bit per cycle,
// with optional two's-complement operands, divide-by-zero/left-zero fast paths and saturation.
module std_fp_div_seq #(
  parameter int WIDTH      = 32,
  parameter int INT_WIDTH  = 24,
  parameter int FRAC_WIDTH = 8,
  parameter bit SIGNED     = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  std_fp_div_seq_if.slave     bus
);
  localparam int ITER = WIDTH + FRAC_WIDTH;
  localparam int CW   = $clog2(ITER + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  if (INT_WIDTH != WIDTH - FRAC_WIDTH || FRAC_WIDTH < 0) begin : g_param_check
    $error("std_fp_div_seq: INT_WIDTH must equal WIDTH - FRAC_WIDTH with FRAC_WIDTH >= 0");
  end

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return (SIGNED && v[WIDTH-1]) ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] sat_max(input logic neg);
    if (!SIGNED) return '1;
    return neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  endfunction

  // A negative result may reach -2^(WIDTH-1), one step further than a positive one.
  function automatic logic q_ovf(input logic [ITER-1:0] qm, input logic neg);
    logic [ITER-1:0] lim;
    if (!SIGNED) lim = ITER'({WIDTH{1'b1}});
    else         lim = ITER'({1'b0, {(WIDTH-1){1'b1}}}) + ITER'(neg);
    return qm > lim;
  endfunction

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [ITER-1:0]  dq_q, dq_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] lraw_q, lraw_d;
  logic             sq_q, sq_d, sr_q, sr_d, dz_q, dz_d, lz_q, lz_d;
  logic [WIDTH-1:0] quo_q, quo_d, remo_q, remo_d;
  logic             done_q, done_d, dbz_q, dbz_d, ovf_q, ovf_d;

  logic [WIDTH:0]   rem_sh;
  logic             ge;
  logic             ovf_c;
  logic [WIDTH-1:0] qt, quot_c, remv_c;

  // dq_q holds the dividend bits still to be consumed and collects quotient bits from the LSB.
  assign rem_sh = {rem_q, dq_q[ITER-1]};
  assign ge     = rem_sh >= {1'b0, div_q};

  assign ovf_c  = q_ovf(dq_q, sq_q);
  assign qt     = dq_q[WIDTH-1:0];
  assign quot_c = ovf_c ? sat_max(sq_q) : (sq_q ? -qt : qt);
  assign remv_c = sr_q ? -rem_q : rem_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dq_d    = dq_q;
    rem_d   = rem_q;
    div_d   = div_q;
    lraw_d  = lraw_q;
    sq_d    = sq_q;
    sr_d    = sr_q;
    dz_d    = dz_q;
    lz_d    = lz_q;
    quo_d   = quo_q;
    remo_d  = remo_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.go) begin
          div_d   = mag(bus.right);
          dq_d    = ITER'(mag(bus.left)) << FRAC_WIDTH;
          rem_d   = '0;
          lraw_d  = bus.left;
          sq_d    = SIGNED && (bus.left[WIDTH-1] ^ bus.right[WIDTH-1]);
          sr_d    = SIGNED && bus.left[WIDTH-1];
          dz_d    = (bus.right == '0);
          lz_d    = (bus.left == '0);
          state_d = S_RUN;
          // Fast paths spend a single cycle in RUN by starting on the last count.
          cnt_d   = (bus.right == '0 || bus.left == '0) ? CW'(ITER - 1) : '0;
        end
      end
      S_RUN: begin
        if (!dz_q && !lz_q) begin
          dq_d  = {dq_q[ITER-2:0], ge};
          rem_d = ge ? WIDTH'(rem_sh - {1'b0, div_q}) : rem_sh[WIDTH-1:0];
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(ITER - 1)) begin
          cnt_d   = '0;
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (dz_q) begin
          quo_d  = sat_max(lraw_q[WIDTH-1]);
          remo_d = lraw_q;
          dbz_d  = 1'b1;
          ovf_d  = 1'b0;
        end else if (lz_q) begin
          quo_d  = '0;
          remo_d = '0;
          dbz_d  = 1'b0;
          ovf_d  = 1'b0;
        end else begin
          quo_d  = quot_c;
          remo_d = remv_c;
          dbz_d  = 1'b0;
          ovf_d  = ovf_c;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dq_q    <= '0;
      rem_q   <= '0;
      div_q   <= '0;
      lraw_q  <= '0;
      sq_q    <= 1'b0;
      sr_q    <= 1'b0;
      dz_q    <= 1'b0;
      lz_q    <= 1'b0;
      quo_q   <= '0;
      remo_q  <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dq_q    <= dq_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
      lraw_q  <= lraw_d;
      sq_q    <= sq_d;
      sr_q    <= sr_d;
      dz_q    <= dz_d;
      lz_q    <= lz_d;
      quo_q   <= quo_d;
      remo_q  <= remo_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.out_quotient  = quo_q;
  assign bus.out_remainder = remo_q;
  assign bus.done          = done_q;
  assign bus.busy          = (state_q != S_IDLE);
  assign bus.div_by_zero   = dbz_q;
  assign bus.overflow      = ovf_q;
endmodule

// File: tb/tb_std_fp_div_seq.sv
// Directed bench for std_fp_div_seq: an unsigned and a signed instance (32/24/8) driven from
// a vector table plus hand-written handshake and reset sequences.
module tb_std_fp_div_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  std_fp_div_seq_if #(.WIDTH(32)) if_u ();
  std_fp_div_seq_if #(.WIDTH(32)) if_s ();

  std_fp_div_seq #(.WIDTH(32), .INT_WIDTH(24), .FRAC_WIDTH(8), .SIGNED(1'b0)) u_dut_u (
    .clk(clk), .reset(rst), .bus(if_u)
  );
  std_fp_div_seq #(.WIDTH(32), .INT_WIDTH(24), .FRAC_WIDTH(8), .SIGNED(1'b1)) u_dut_s (
    .clk(clk), .reset(rst), .bus(if_s)
  );

  typedef struct {
    string       name;
    bit          sgn;
    logic [31:0] l;
    logic [31:0] r;
    logic [31:0] q;
    logic [31:0] rm;
    logic        dz;
    logic        ov;
    int          lat;
  } vec_t;

  vec_t vt[18];
  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input bit sgn, input logic g, input logic [31:0] l, input logic [31:0] r);
    if (sgn) begin if_s.go = g; if_s.left = l; if_s.right = r; end
    else     begin if_u.go = g; if_u.left = l; if_u.right = r; end
  endtask

  function automatic logic [31:0] rd_q(input bit sgn);
    return sgn ? if_s.out_quotient : if_u.out_quotient;
  endfunction
  function automatic logic [31:0] rd_r(input bit sgn);
    return sgn ? if_s.out_remainder : if_u.out_remainder;
  endfunction
  function automatic logic rd_done(input bit sgn);
    return sgn ? if_s.done : if_u.done;
  endfunction
  function automatic logic rd_busy(input bit sgn);
    return sgn ? if_s.busy : if_u.busy;
  endfunction

  // Counts cycles from the current sample point until done is seen, bounded.
  task automatic wait_done(input bit sgn, input string nm, output int lat);
    bit got = 1'b0;
    lat = 0;
    while (!got && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (rd_done(sgn)) got = 1'b1;
    end
    if (!got) chk({nm, "_timeout"}, 64'(lat), 64'd0);
  endtask

  task automatic count_dones(input bit sgn, input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (rd_done(sgn)) n++;
    end
  endtask

  task automatic run_op(input bit sgn, input logic [31:0] l, input logic [31:0] r, input string nm,
                        output int lat, output logic bsy1);
    @(negedge clk);
    drive(sgn, 1'b1, l, r);
    @(posedge clk); #1;
    drive(sgn, 1'b0, l, r);
    bsy1 = rd_busy(sgn);
    wait_done(sgn, nm, lat);
  endtask

  initial begin
    int lat;
    int n;
    logic b;

    vt[0]  = '{"u_3_over_2",     1'b0, 32'h0000_0300, 32'h0000_0200, 32'h0000_0180, 32'h0, 1'b0, 1'b0, 41};
    vt[1]  = '{"s_m7_over_3",    1'b1, 32'hFFFF_F900, 32'h0000_0300, 32'hFFFF_FDAB, 32'hFFFF_FF00, 1'b0, 1'b0, 41};
    vt[2]  = '{"s_7_over_3",     1'b1, 32'h0000_0700, 32'h0000_0300, 32'h0000_0255, 32'h0000_0100, 1'b0, 1'b0, 41};
    vt[3]  = '{"s_7_over_m3",    1'b1, 32'h0000_0700, 32'hFFFF_FD00, 32'hFFFF_FDAB, 32'h0000_0100, 1'b0, 1'b0, 41};
    vt[4]  = '{"s_m7_over_m3",   1'b1, 32'hFFFF_F900, 32'hFFFF_FD00, 32'h0000_0255, 32'hFFFF_FF00, 1'b0, 1'b0, 41};
    vt[5]  = '{"u_dz",           1'b0, 32'h0000_0005, 32'h0,         32'hFFFF_FFFF, 32'h0000_0005, 1'b1, 1'b0, 2};
    vt[6]  = '{"s_dz_neg",       1'b1, 32'hFFFF_FF00, 32'h0,         32'h8000_0000, 32'hFFFF_FF00, 1'b1, 1'b0, 2};
    vt[7]  = '{"s_dz_pos",       1'b1, 32'h0000_0100, 32'h0,         32'h7FFF_FFFF, 32'h0000_0100, 1'b1, 1'b0, 2};
    vt[8]  = '{"u_left_zero",    1'b0, 32'h0,         32'h0000_0300, 32'h0,         32'h0,         1'b0, 1'b0, 2};
    vt[9]  = '{"u_ovf",          1'b0, 32'hFFFF_FF00, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0,         1'b0, 1'b1, 41};
    vt[10] = '{"s_ovf_pos",      1'b1, 32'h7FFF_FF00, 32'h0000_0001, 32'h7FFF_FFFF, 32'h0,         1'b0, 1'b1, 41};
    vt[11] = '{"u_max_no_ovf",   1'b0, 32'h00FF_FFFF, 32'h0000_0001, 32'hFFFF_FF00, 32'h0,         1'b0, 1'b0, 41};
    vt[12] = '{"u_first_ovf",    1'b0, 32'h0100_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0,         1'b0, 1'b1, 41};
    vt[13] = '{"s_min_exact",    1'b1, 32'h8000_0000, 32'h0000_0100, 32'h8000_0000, 32'h0,         1'b0, 1'b0, 41};
    vt[14] = '{"s_min_over_m1",  1'b1, 32'h8000_0000, 32'hFFFF_FF00, 32'h7FFF_FFFF, 32'h0,         1'b0, 1'b1, 41};
    vt[15] = '{"u_1_over_3",     1'b0, 32'h0000_0100, 32'h0000_0300, 32'h0000_0055, 32'h0000_0100, 1'b0, 1'b0, 41};
    vt[16] = '{"s_ovf_rem_pos",  1'b1, 32'h7FFF_FFFF, 32'h0000_0003, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 41};
    vt[17] = '{"s_ovf_rem_neg",  1'b1, 32'h8000_0001, 32'h0000_0003, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 41};

    drive(1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 32'h0, 32'h0);
    #1;
    chk("rst_q_u",    64'(if_u.out_quotient), 64'd0);
    chk("rst_r_u",    64'(if_u.out_remainder), 64'd0);
    chk("rst_flags_u", 64'({if_u.done, if_u.busy, if_u.div_by_zero, if_u.overflow}), 64'd0);
    chk("rst_q_s",    64'(if_s.out_quotient), 64'd0);
    chk("rst_flags_s", 64'({if_s.done, if_s.busy, if_s.div_by_zero, if_s.overflow}), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      run_op(vt[i].sgn, vt[i].l, vt[i].r, vt[i].name, lat, b);
      chk({vt[i].name, "_busy"}, 64'(b), 64'd1);
      chk({vt[i].name, "_lat"},  64'(lat), 64'(vt[i].lat));
      chk({vt[i].name, "_q"},    64'(rd_q(vt[i].sgn)), 64'(vt[i].q));
      chk({vt[i].name, "_r"},    64'(rd_r(vt[i].sgn)), 64'(vt[i].rm));
      chk({vt[i].name, "_dz"},   64'(vt[i].sgn ? if_s.div_by_zero : if_u.div_by_zero), 64'(vt[i].dz));
      chk({vt[i].name, "_ov"},   64'(vt[i].sgn ? if_s.overflow : if_u.overflow), 64'(vt[i].ov));
      @(posedge clk); #1;
      chk({vt[i].name, "_idle"}, 64'({rd_done(vt[i].sgn), rd_busy(vt[i].sgn)}), 64'd0);
    end

    // go pulsed with new operands in RUN cycle 5 must be ignored
    @(negedge clk);
    drive(1'b0, 1'b1, 32'h0000_0300, 32'h0000_0200);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 32'h0000_0300, 32'h0000_0200);
    repeat (4) @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b1, 32'h0000_0700, 32'h0000_0100);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 32'h0000_0700, 32'h0000_0100);
    wait_done(1'b0, "ign", lat);
    chk("ign_lat", 64'(lat + 5), 64'd41);
    chk("ign_q",   64'(if_u.out_quotient), 64'h180);
    count_dones(1'b0, 50, n);
    chk("ign_extra_done", 64'(n), 64'd0);

    // go held through done: second operation accepted in the done cycle
    @(negedge clk);
    drive(1'b0, 1'b1, 32'h0000_0300, 32'h0000_0200);
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 32'h0000_0100, 32'h0000_0300);
    wait_done(1'b0, "b2b_a", lat);
    chk("b2b_a_lat", 64'(lat), 64'd41);
    chk("b2b_a_q",   64'(if_u.out_quotient), 64'h180);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 32'h0000_0100, 32'h0000_0300);
    chk("b2b_b_busy", 64'(if_u.busy), 64'd1);
    wait_done(1'b0, "b2b_b", lat);
    chk("b2b_b_lat", 64'(lat), 64'd41);
    chk("b2b_b_q",   64'(if_u.out_quotient), 64'h55);
    chk("b2b_b_r",   64'(if_u.out_remainder), 64'h100);

    // reset asserted in RUN cycle 10 clears outputs at once and aborts the operation
    @(negedge clk);
    drive(1'b0, 1'b1, 32'h0000_0700, 32'h0000_0300);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 32'h0000_0700, 32'h0000_0300);
    repeat (9) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_q",     64'(if_u.out_quotient), 64'd0);
    chk("mid_rst_r",     64'(if_u.out_remainder), 64'd0);
    chk("mid_rst_flags", 64'({if_u.done, if_u.busy, if_u.div_by_zero, if_u.overflow}), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    count_dones(1'b0, 50, n);
    chk("mid_rst_no_done", 64'(n), 64'd0);
    run_op(1'b0, 32'h0000_0300, 32'h0000_0200, "post_rst", lat, b);
    chk("post_rst_lat", 64'(lat), 64'd41);
    chk("post_rst_q",   64'(if_u.out_quotient), 64'h180);
    chk("post_rst_r",   64'(if_u.out_remainder), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
